// File: rtl/cc1200_tx_pkg.sv
// cc1200_tx_pkg: shared constants and state type for the CC1200 transmit sample FIFO
package cc1200_tx_pkg;
  localparam int SAMPLE_W = 12;
  localparam int DEF_DEPTH = 64;
  localparam int DEF_START_LEVEL = 16;
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/cc1200_txfifo_ram.sv
// cc1200_txfifo_ram: DEPTH x SAMPLE_W simple dual-port store (clk, we/waddr/wdata sync write, raddr/rdata async read)
module cc1200_txfifo_ram
  import cc1200_tx_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [SAMPLE_W-1:0] rdata
);
  logic [SAMPLE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/cc1200_tx_sample_fifo.sv
// cc1200_tx_sample_fifo: show-ahead sample FIFO gating GetDataEn by start level and pair alignment (ports: clk, rst, wr_en/wr_data/full, GetDataEn/GetData/Next_data, level, ovf, udf; optional flush with CC1200_TXFIFO_FLUSH_EN)
module cc1200_tx_sample_fifo
  import cc1200_tx_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = 6,
  parameter int START_LEVEL = DEF_START_LEVEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic                full,
  output logic                GetDataEn,
  output logic [SAMPLE_W-1:0] GetData,
  input  logic                Next_data,
  output logic [AW:0]         level,
  output logic                ovf,
  output logic                udf
`ifdef CC1200_TXFIFO_FLUSH_EN
  , input logic               flush
`endif
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nxt;
  logic pair_phase, pp_nxt, push, pop_eff, go, stop, clr;
  logic [SAMPLE_W-1:0] head;
  state_t state, state_nxt;
`ifdef CC1200_TXFIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  cc1200_txfifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk), .we(push), .waddr(wr_ptr), .wdata(wr_data), .raddr(rd_ptr), .rdata(head)
  );
  always_comb begin
    pop_eff = Next_data && count != '0;
    push = wr_en && (!full || pop_eff);
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop_eff);
    pp_nxt = pair_phase ^ pop_eff;
    go = state == ST_IDLE && count >= (AW+1)'(START_LEVEL);
    // exit only on a pair boundary once fewer than a full pair remains
    stop = state == ST_ACTIVE && !pp_nxt && count_nxt < (AW+1)'(2);
    state_nxt = go ? ST_ACTIVE : stop ? ST_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pair_phase <= 1'b0;
      state <= ST_IDLE;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      pair_phase <= go ? 1'b0 : pp_nxt;
      state <= state_nxt;
      ovf <= ovf | (wr_en & ~push);
      udf <= udf | (Next_data & ~pop_eff);
    end
  end
  // head is undefined storage while empty, so present zero instead
  assign GetData = count != '0 ? head : '0;
  assign GetDataEn = state == ST_ACTIVE;
  assign full = count == (AW+1)'(DEPTH);
  assign level = count;
endmodule

// File: tb/tb_cc1200_tx_sample_fifo.sv
// tb_cc1200_tx_sample_fifo: directed table-driven and sequence checks for cc1200_tx_sample_fifo
module tb_cc1200_tx_sample_fifo;
  logic clk, rst, wr_en, Next_data, full, GetDataEn, ovf, udf;
  logic [11:0] wr_data, GetData;
  logic [6:0] level;
  int checks = 0;
  int failures = 0;
`ifdef CC1200_TXFIFO_FLUSH_EN
  logic flush = 1'b0;
`endif
  typedef struct {
    logic wr;
    logic [11:0] d;
    logic nd;
    logic en;
    logic [11:0] data;
    int lvl;
  } vec_t;
  vec_t v[$];
  cc1200_tx_sample_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .GetDataEn(GetDataEn), .GetData(GetData), .Next_data(Next_data),
    .level(level), .ovf(ovf), .udf(udf)
`ifdef CC1200_TXFIFO_FLUSH_EN
    , .flush(flush)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic vec_t mk(logic wr, logic [11:0] d, logic nd, logic en, logic [11:0] data, int lvl);
    vec_t t;
    t.wr = wr;
    t.d = d;
    t.nd = nd;
    t.en = en;
    t.data = data;
    t.lvl = lvl;
    return t;
  endfunction
  task automatic cyc(input logic w, input logic [11:0] d, input logic n);
    wr_en = w;
    wr_data = d;
    Next_data = n;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    Next_data = 1'b0;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask
  initial begin
    wr_en = 1'b0;
    wr_data = '0;
    Next_data = 1'b0;
    for (int i = 0; i < 16; i++) v.push_back(mk(1'b1, 12'(i + 1), 1'b0, 1'b0, 12'h001, i + 1));
    v.push_back(mk(1'b0, 12'h0, 1'b0, 1'b1, 12'h001, 16));
    for (int k = 1; k <= 16; k++)
      for (int j = 0; j < 4; j++)
        v.push_back(mk(1'b0, 12'h0, j == 0, k < 16, k < 16 ? 12'(k + 1) : 12'h0, 16 - k));
    rst = 1'b1;
    cyc(1'b0, 12'h0, 1'b0);
    cyc(1'b1, 12'h5A5, 1'b1);
    chk("rst_en", GetDataEn, 0);
    chk("rst_data", GetData, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    rst = 1'b0;
    foreach (v[i]) begin
      cyc(v[i].wr, v[i].d, v[i].nd);
      chk($sformatf("vec%0d_en", i), GetDataEn, v[i].en);
      chk($sformatf("vec%0d_data", i), GetData, v[i].data);
      chk($sformatf("vec%0d_level", i), level, v[i].lvl);
    end
    chk("burst_udf", udf, 0);
    chk("burst_ovf", ovf, 0);
    for (int i = 0; i < 17; i++) cyc(1'b1, 12'(12'h101 + i), 1'b0);
    chk("a_start_en", GetDataEn, 1);
    for (int j = 1; j <= 16; j++) begin
      cyc(1'b0, 12'h0, 1'b1);
      if (j == 15) chk("a_pop15_en", GetDataEn, 1);
    end
    chk("a_end_en", GetDataEn, 0);
    chk("a_end_level", level, 1);
    chk("a_end_data", GetData, 12'h111);
    for (int i = 0; i < 15; i++) cyc(1'b1, 12'(12'h112 + i), 1'b0);
    chk("a_refill_en", GetDataEn, 0);
    chk("a_refill_level", level, 16);
    cyc(1'b0, 12'h0, 1'b0);
    chk("a_restart_en", GetDataEn, 1);
    chk("a_restart_data", GetData, 12'h111);
    for (int j = 1; j <= 15; j++) cyc(1'b0, 12'h0, 1'b1);
    chk("b_half_en", GetDataEn, 1);
    chk("b_half_level", level, 1);
    chk("b_half_data", GetData, 12'h120);
    for (int j = 0; j < 5; j++) cyc(1'b0, 12'h0, 1'b0);
    chk("b_wait_en", GetDataEn, 1);
    cyc(1'b1, 12'h121, 1'b0);
    chk("b_second_en", GetDataEn, 1);
    cyc(1'b0, 12'h0, 1'b1);
    chk("b_end_en", GetDataEn, 0);
    chk("b_end_data", GetData, 12'h121);
    cyc(1'b0, 12'h0, 1'b1);
    chk("b_drain_level", level, 0);
    chk("b_drain_udf", udf, 0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 12'(12'h200 + i), 1'b0);
    chk("f_full", full, 1);
    chk("f_level", level, 64);
    chk("f_ovf0", ovf, 0);
    cyc(1'b1, 12'h3FF, 1'b1);
    chk("f_pp_level", level, 64);
    chk("f_pp_ovf", ovf, 0);
    chk("f_pp_data", GetData, 12'h201);
    cyc(1'b1, 12'h3EE, 1'b0);
    chk("f_drop_ovf", ovf, 1);
    chk("f_drop_level", level, 64);
    for (int j = 0; j < 64; j++) begin
      chk($sformatf("f_rd%0d", j), GetData, j < 63 ? 12'(12'h201 + j) : 12'h3FF);
      cyc(1'b0, 12'h0, 1'b1);
    end
    chk("f_empty_level", level, 0);
    chk("f_empty_full", full, 0);
    chk("f_empty_en", GetDataEn, 0);
    cyc(1'b0, 12'h0, 1'b1);
    chk("u_udf", udf, 1);
    chk("u_level", level, 0);
    chk("u_data", GetData, 0);
    cyc(1'b1, 12'h0AA, 1'b0);
    chk("u_ptr_data", GetData, 12'h0AA);
    chk("u_ptr_level", level, 1);
`ifdef CC1200_TXFIFO_FLUSH_EN
    for (int i = 0; i < 20; i++) cyc(1'b1, 12'(12'h400 + i), 1'b0);
    cyc(1'b0, 12'h0, 1'b0);
    chk("fl_pre_en", GetDataEn, 1);
    flush = 1'b1;
    cyc(1'b1, 12'h7FF, 1'b1);
    flush = 1'b0;
    chk("fl_en", GetDataEn, 0);
    chk("fl_level", level, 0);
    chk("fl_data", GetData, 0);
    chk("fl_ovf", ovf, 0);
    chk("fl_udf", udf, 0);
`endif
    for (int i = 0; i < 20; i++) cyc(1'b1, 12'(12'h300 + i), 1'b0);
    cyc(1'b0, 12'h0, 1'b0);
    chk("r_pre_en", GetDataEn, 1);
    cyc(1'b0, 12'h0, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 12'h123, 1'b1);
    rst = 1'b0;
    chk("r_en", GetDataEn, 0);
    chk("r_data", GetData, 0);
    chk("r_level", level, 0);
    chk("r_full", full, 0);
    chk("r_ovf", ovf, 0);
    chk("r_udf", udf, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
